// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter and its matching receiver.
// Frame timing depends on SERIAL_FRAME_TX_PARITY_EN through the parity-bit count passed to frame_cycles.
package serial_frame_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Total busy cycles of one frame: start + data + optional parity + stop bits.
   function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                input int unsigned clks_per_bit,
                                                input int unsigned parity_bits);
      return (32'd2 + data_w + parity_bits) * clks_per_bit;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n > 32'd1) begin
         return $clog2(n);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the last count of each bit.
// Held at zero while restart is high so every bit period starts from a clean count.
module bit_timer
   import serial_frame_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned   CW   = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 32'd1);
   localparam logic [CW-1:0] ZERO = CW'(32'd0);
   localparam logic [CW-1:0] ONE  = CW'(32'd1);

   logic [CW-1:0] count_r;

   // Free-running period counter, wrapping on the last count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= ZERO;
      end else if (restart || (count_r == LAST)) begin
         count_r <= ZERO;
      end else begin
         count_r <= count_r + ONE;
      end
   end

   assign tick = !restart && (count_r == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Frame-serializing transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit between the data and stop bits.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic              input_clock1_clk_1,
   input  logic              input_push_button2_rst_n_2,
   input  logic              input_push_button3_load_3,
   input  logic [DATA_W-1:0] input_bus_data_4,
   output logic              output_led1_tx_0_5,
   output logic              output_led2_busy_0_6,
   output logic              output_led3_done_0_7
);

   localparam int unsigned   IW       = cnt_width(DATA_W);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 32'd1);
   localparam logic [IW-1:0] IDX_ZERO = IW'(32'd0);
   localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
   localparam tx_state_e AFTER_DATA = PARITY;
`else
   localparam tx_state_e AFTER_DATA = STOP;
`endif

   logic              clk;
   logic              rst_n;
   tx_state_e         state_r;
   tx_state_e         state_s;
   logic [DATA_W-1:0] shift_r;
   logic [DATA_W-1:0] shift_s;
   logic [IW-1:0]     bit_idx_r;
   logic [IW-1:0]     bit_idx_s;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic              parity_r;
   logic              parity_s;
`endif
   logic              tx_r;
   logic              busy_r;
   logic              done_r;
   logic              tx_s;
   logic              busy_s;
   logic              done_s;
   logic              accept_s;
   logic              restart_s;
   logic              tick_s;

   assign clk       = input_clock1_clk_1;
   assign rst_n     = input_push_button2_rst_n_2;
   assign accept_s  = (state_r == IDLE) && input_push_button3_load_3;
   // The timer only runs inside a frame, so every state entry sees a fresh count.
   assign restart_s = (state_r == IDLE);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart_s),
      .tick    (tick_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; bit boundaries are the only transition points inside a frame.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (input_push_button3_load_3) begin
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (tick_s) begin
               state_s = DATA;
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (tick_s && (bit_idx_r == LAST_IDX)) begin
               state_s = AFTER_DATA;
            end else begin
               state_s = DATA;
            end
         end
`ifdef SERIAL_FRAME_TX_PARITY_EN
         PARITY: begin
            if (tick_s) begin
               state_s = STOP;
            end else begin
               state_s = PARITY;
            end
         end
`endif
         STOP: begin
            if (tick_s) begin
               state_s = IDLE;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Shift register, bit index and parity accumulator updates.
   always_comb begin
      shift_s   = shift_r;
      bit_idx_s = bit_idx_r;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_s  = parity_r;
`endif
      if (accept_s) begin
         shift_s   = input_bus_data_4;
         bit_idx_s = IDX_ZERO;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_s  = 1'b0;
`endif
      end else if ((state_r == DATA) && tick_s) begin
         shift_s = shift_r >> 1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_s = parity_r ^ shift_r[0];
`endif
         if (bit_idx_r == LAST_IDX) begin
            bit_idx_s = IDX_ZERO;
         end else begin
            bit_idx_s = bit_idx_r + IDX_ONE;
         end
      end else begin
         shift_s = shift_r;
      end
   end

   // Output values for the coming cycle, decoded from the state being entered.
   always_comb begin
      tx_s = IDLE_LEVEL;
      case (state_s)
         START:   tx_s = START_LEVEL;
         DATA:    tx_s = shift_s[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
         PARITY:  tx_s = parity_s;
`endif
         STOP:    tx_s = IDLE_LEVEL;
         default: tx_s = IDLE_LEVEL;
      endcase
      busy_s = (state_s != IDLE);
      done_s = (state_r == STOP) && (state_s == IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_r   <= {DATA_W{1'b0}};
         bit_idx_r <= IDX_ZERO;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_r  <= 1'b0;
`endif
         tx_r      <= IDLE_LEVEL;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         shift_r   <= shift_s;
         bit_idx_r <= bit_idx_s;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_r  <= parity_s;
`endif
         tx_r      <= tx_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign output_led1_tx_0_5   = tx_r;
   assign output_led2_busy_0_6 = busy_r;
   assign output_led3_done_0_7 = done_r;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a bit-queue frame model checked every cycle plus hand-computed waveform points.
// Honors SERIAL_FRAME_TX_PARITY_EN the same way the design does.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int DW = 8;
   localparam int CA = 4;
   localparam int CB = 1;
   localparam int FA = (2 + DW + P) * CA;
   localparam int FB = (2 + DW + P) * CB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_a = 1'b0;
   logic          load_b = 1'b0;
   logic [DW-1:0] data_a = 8'h00;
   logic [DW-1:0] data_b = 8'h00;
   logic          tx_a, busy_a, done_a;
   logic          tx_b, busy_b, done_b;

   int n_pass  = 0;
   int n_total = 0;

   logic tr_tx   [0:127];
   logic tr_busy [0:127];
   logic tr_done [0:127];
   logic trb_tx  [0:31];
   logic trb_busy[0:31];
   logic trb_done[0:31];

   always #5 clk = ~clk;

   serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CA)) dut_a (
      .input_clock1_clk_1        (clk),
      .input_push_button2_rst_n_2(rst_n),
      .input_push_button3_load_3 (load_a),
      .input_bus_data_4          (data_a),
      .output_led1_tx_0_5        (tx_a),
      .output_led2_busy_0_6      (busy_a),
      .output_led3_done_0_7      (done_a)
   );

   serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CB)) dut_b (
      .input_clock1_clk_1        (clk),
      .input_push_button2_rst_n_2(rst_n),
      .input_push_button3_load_3 (load_b),
      .input_bus_data_4          (data_b),
      .output_led1_tx_0_5        (tx_b),
      .output_led2_busy_0_6      (busy_b),
      .output_led3_done_0_7      (done_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Frame model: an accepted word becomes a queue of line levels, one per clock cycle.
   bit   qa[$];
   bit   qb[$];
   logic ea_tx = 1'b1, ea_busy = 1'b0, ea_done = 1'b0;
   logic eb_tx = 1'b1, eb_busy = 1'b0, eb_done = 1'b0;
   bit   model_on = 1'b0;

   always @(posedge clk) begin : model_a
      if (!rst_n) begin
         qa.delete();
         ea_tx <= 1'b1; ea_busy <= 1'b0; ea_done <= 1'b0;
      end else begin
         if (!ea_busy && load_a) begin
            for (int i = 0; i < CA; i++) qa.push_back(1'b0);
            for (int b = 0; b < DW; b++)
               for (int i = 0; i < CA; i++) qa.push_back(data_a[b]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
            for (int i = 0; i < CA; i++) qa.push_back(^data_a);
`endif
            for (int i = 0; i < CA; i++) qa.push_back(1'b1);
         end
         if (qa.size() > 0) begin
            ea_tx <= qa.pop_front(); ea_busy <= 1'b1; ea_done <= 1'b0;
         end else begin
            ea_tx <= 1'b1; ea_busy <= 1'b0; ea_done <= ea_busy;
         end
      end
      model_on <= 1'b1;
   end

   always @(posedge clk) begin : model_b
      if (!rst_n) begin
         qb.delete();
         eb_tx <= 1'b1; eb_busy <= 1'b0; eb_done <= 1'b0;
      end else begin
         if (!eb_busy && load_b) begin
            for (int i = 0; i < CB; i++) qb.push_back(1'b0);
            for (int b = 0; b < DW; b++)
               for (int i = 0; i < CB; i++) qb.push_back(data_b[b]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
            for (int i = 0; i < CB; i++) qb.push_back(^data_b);
`endif
            for (int i = 0; i < CB; i++) qb.push_back(1'b1);
         end
         if (qb.size() > 0) begin
            eb_tx <= qb.pop_front(); eb_busy <= 1'b1; eb_done <= 1'b0;
         end else begin
            eb_tx <= 1'b1; eb_busy <= 1'b0; eb_done <= eb_busy;
         end
      end
   end

   always @(negedge clk) begin : compare
      if (model_on) begin
         chk("model_tx_a",   tx_a,   ea_tx);
         chk("model_busy_a", busy_a, ea_busy);
         chk("model_done_a", done_a, ea_done);
         chk("model_tx_b",   tx_b,   eb_tx);
         chk("model_busy_b", busy_b, eb_busy);
         chk("model_done_b", done_b, eb_done);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Load d, then record ncyc cycles; optional extra load and reset pulses at given cycle numbers.
   task automatic run_a(input logic [DW-1:0] d, input int extra_at, input logic [DW-1:0] extra_d,
                        input int rst_at, input int ncyc);
      data_a = d; load_a = 1'b1;
      step();
      load_a = 1'b0; data_a = ~d;
      for (int c = 1; c <= ncyc; c++) begin
         tr_tx[c] = tx_a; tr_busy[c] = busy_a; tr_done[c] = done_a;
         if (c == extra_at) begin
            load_a = 1'b1; data_a = extra_d;
         end
         if (c == rst_at) rst_n = 1'b0;
         step();
         load_a = 1'b0; rst_n = 1'b1;
      end
   endtask

   function automatic int count_done(input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (tr_done[c] === 1'b1) n++;
      return n;
   endfunction

   initial begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
      logic [0:FB-1] pat_b = 11'b01000000011;
`else
      logic [0:FB-1] pat_b = 10'b0100000001;
`endif
      rst_n = 1'b0;
      repeat (10) begin
         step();
         chk("rst_tx", tx_a, 32'd1);
         chk("rst_busy", busy_a, 32'd0);
         chk("rst_done", done_a, 32'd0);
         chk("rst_tx_b", tx_b, 32'd1);
      end
      rst_n = 1'b1;
      step(); step();

      // 0xA5: start, 1,0,1,0,0,1,0,1, stop.
      run_a(8'hA5, 0, 8'h00, 0, FA + 3);
      chk("a5_c1_start", tr_tx[1], 32'd0);
      chk("a5_c1_busy", tr_busy[1], 32'd1);
      chk("a5_c4_start", tr_tx[4], 32'd0);
      chk("a5_c5_b0", tr_tx[5], 32'd1);
      chk("a5_c8_b0", tr_tx[8], 32'd1);
      chk("a5_c9_b1", tr_tx[9], 32'd0);
      chk("a5_c13_b2", tr_tx[13], 32'd1);
      chk("a5_c17_b3", tr_tx[17], 32'd0);
      chk("a5_c21_b4", tr_tx[21], 32'd0);
      chk("a5_c25_b5", tr_tx[25], 32'd1);
      chk("a5_c29_b6", tr_tx[29], 32'd0);
      chk("a5_c33_b7", tr_tx[33], 32'd1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
      chk("a5_c37_parity", tr_tx[37], 32'd0);
      chk("a5_c41_stop", tr_tx[41], 32'd1);
      chk("a5_c45_done", tr_done[45], 32'd1);
`else
      chk("a5_c37_stop", tr_tx[37], 32'd1);
      chk("a5_c41_done", tr_done[41], 32'd1);
      chk("a5_c41_busy", tr_busy[41], 32'd0);
`endif
      chk("a5_last_busy", tr_busy[FA], 32'd1);
      chk("a5_last_done", tr_done[FA], 32'd0);
      chk("a5_done_once", count_done(1, FA + 3), 32'd1);

      // 0x07 carries three ones: parity bit 1.
      run_a(8'h07, 0, 8'h00, 0, FA + 3);
      chk("x07_c13_b2", tr_tx[13], 32'd1);
      chk("x07_c17_b3", tr_tx[17], 32'd0);
      chk("x07_c33_b7", tr_tx[33], 32'd0);
`ifdef SERIAL_FRAME_TX_PARITY_EN
      chk("x07_c37_parity", tr_tx[37], 32'd1);
      chk("x07_c40_parity", tr_tx[40], 32'd1);
      chk("x07_c44_stop", tr_tx[44], 32'd1);
      chk("x07_c45_done", tr_done[45], 32'd1);
`else
      chk("x07_c37_stop", tr_tx[37], 32'd1);
      chk("x07_c41_done", tr_done[41], 32'd1);
`endif

      // 0x3C with an ignored 0xFF load at cycle 10: bits 0,0,1,1,1,1,0,0.
      run_a(8'h3C, 10, 8'hFF, 0, FA + 3);
      chk("x3c_c5_b0", tr_tx[5], 32'd0);
      chk("x3c_c13_b2", tr_tx[13], 32'd1);
      chk("x3c_c29_b6", tr_tx[29], 32'd0);
      chk("x3c_c33_b7", tr_tx[33], 32'd0);
      chk("x3c_done_once", count_done(1, FA + 3), 32'd1);
      chk("x3c_idle_after", tr_busy[FA + 3], 32'd0);

      // 0x5A aborted by reset at cycle 20, then 0xC3 (1,1,0,0,0,0,1,1) loaded at cycle 25.
      run_a(8'h5A, 25, 8'hC3, 20, 25 + FA + 3);
      chk("abort_c20_busy", tr_busy[20], 32'd1);
      chk("abort_c21_tx", tr_tx[21], 32'd1);
      chk("abort_c21_busy", tr_busy[21], 32'd0);
      chk("abort_no_done", count_done(1, 25), 32'd0);
      chk("reload_c26_start", tr_tx[26], 32'd0);
      chk("reload_c30_b0", tr_tx[30], 32'd1);
      chk("reload_c38_b2", tr_tx[38], 32'd0);
      chk("reload_c54_b6", tr_tx[54], 32'd1);
      chk("reload_done", tr_done[25 + FA + 1], 32'd1);
      chk("reload_done_once", count_done(1, 25 + FA + 3), 32'd1);

      // Reset and load together: the load is lost.
      rst_n = 1'b0; load_a = 1'b1; data_a = 8'hFF;
      step();
      rst_n = 1'b1; load_a = 1'b0;
      chk("rstload_busy", busy_a, 32'd0);
      chk("rstload_tx", tx_a, 32'd1);
      step();
      chk("rstload_still_idle", busy_a, 32'd0);

      // CLKS_PER_BIT = 1, load held for two back-to-back frames of 0x01.
      data_b = 8'h01; load_b = 1'b1;
      step();
      for (int c = 1; c <= 2 * FB + 3; c++) begin
         trb_tx[c] = tx_b; trb_busy[c] = busy_b; trb_done[c] = done_b;
         if (c == FB + 2) load_b = 1'b0;
         step();
      end
      for (int c = 1; c <= FB; c++) begin
         chk("b_frame1_tx", trb_tx[c], pat_b[c-1]);
         chk("b_frame2_tx", trb_tx[FB + 1 + c], pat_b[c-1]);
      end
      chk("b_gap_tx", trb_tx[FB + 1], 32'd1);
      chk("b_gap_busy", trb_busy[FB + 1], 32'd0);
      chk("b_done1", trb_done[FB + 1], 32'd1);
      chk("b_done2", trb_done[2 * FB + 2], 32'd1);
      chk("b_no_third", trb_busy[2 * FB + 3], 32'd0);

      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
